// File: rtl/klein_sched.sv
// klein_sched: two-requester round-robin front end for a serial KLEIN core.
// One encryption is in flight at a time: IDLE -> LOAD -> RUN -> RESP -> IDLE.
module klein_sched #(
   parameter int KEY_W   = 80,
   parameter int TIMEOUT = 255
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [63:0]      req0_pt,
   input  logic [63:0]      req1_pt,
   input  logic [KEY_W-1:0] req0_key,
   input  logic [KEY_W-1:0] req1_key,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [63:0]      rsp_ct,
   output logic             rsp_err,
   output logic             core_start,
   output logic [63:0]      core_pt,
   output logic [KEY_W-1:0] core_key,
   input  logic             core_ready,
   input  logic [63:0]      core_ct,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   state_t           state_q, state_d;
   logic             last_q, last_d;      // requester served most recently
   logic             id_q, id_d;          // owner of the operation in flight
   logic [63:0]      core_pt_q, core_pt_d;
   logic [KEY_W-1:0] core_key_q, core_key_d;
   logic [63:0]      rsp_ct_q, rsp_ct_d;
   logic             rsp_err_q, rsp_err_d;
   logic [7:0]       cnt_q, cnt_d;        // RUN cycles elapsed, saturating
   logic             rdy_q;               // core_ready one cycle ago
   logic             grant0, grant1, done;

   // Round-robin grant (a tie goes to the requester not served last) and core completion edge.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
      done   = core_ready && !rdy_q;
   end

   // Next-state and output decode; every target defaults to hold / inactive.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      id_d       = id_q;
      core_pt_d  = core_pt_q;
      core_key_d = core_key_q;
      rsp_ct_d   = rsp_ct_q;
      rsp_err_d  = rsp_err_q;
      cnt_d      = cnt_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      case (state_q)
         IDLE: begin
            busy       = 1'b0;
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0) begin
               core_pt_d  = req0_pt;
               core_key_d = req0_key;
               id_d       = 1'b0;
               last_d     = 1'b0;
               state_d    = LOAD;
            end else if (grant1) begin
               core_pt_d  = req1_pt;
               core_key_d = req1_key;
               id_d       = 1'b1;
               last_d     = 1'b1;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            core_start = 1'b1;
            cnt_d      = 8'd0;
            state_d    = RUN;
         end
         RUN: begin
            // Completion takes priority over a timeout landing in the same cycle.
            if (done) begin
               rsp_ct_d  = core_ct;
               rsp_err_d = 1'b0;
               state_d   = RESP;
            end else if (cnt_q == TO_LIMIT) begin
               rsp_ct_d  = 64'd0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         id_q       <= 1'b0;
         core_pt_q  <= 64'd0;
         core_key_q <= '0;
         rsp_ct_q   <= 64'd0;
         rsp_err_q  <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         id_q       <= id_d;
         core_pt_q  <= core_pt_d;
         core_key_q <= core_key_d;
         rsp_ct_q   <= rsp_ct_d;
         rsp_err_q  <= rsp_err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Track core_ready every cycle so a level left high from an earlier operation is not taken as done.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= core_ready;
      end
   end

   assign core_pt  = core_pt_q;
   assign core_key = core_key_q;
   assign rsp_ct   = rsp_ct_q;
   assign rsp_err  = rsp_err_q;
   assign rsp_id   = id_q;

endmodule
